// File: rtl/phase_tick_gen.sv
// -----------------------------------------------------------------------------
// phase_tick_gen
//
// Upstream timing stage for the traffic-light sequencer. Each of the four
// phases is timed for a switch-programmed number of seconds. When the time
// runs out, or when a debounced btnC press arrives, the block emits a
// one-clock `trig` pulse and moves on to the next phase.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btnC       raw manual-advance pushbutton (asynchronous, bouncy)
//   sw[15:0]   per-phase durations in seconds, 4 bits per phase
//              (sw[3:0] phase 0 ... sw[15:12] phase 3); 0 selects DEFAULT_SECS
//   trig       one-clock advance pulse to the sequencer
//   phase      index of the phase currently being timed
//   secs_left  whole seconds remaining in the current phase
// -----------------------------------------------------------------------------
module phase_tick_gen #(
  parameter int unsigned TICK_DIV        = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DEFAULT_SECS    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btnC,
  input  logic [15:0] sw,
  output logic        trig,
  output logic [1:0]  phase,
  output logic [3:0]  secs_left
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  localparam logic [PW-1:0] TICK_LAST     = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST       = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    DEFAULT_FIELD = 4'(DEFAULT_SECS);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FIRE  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Button path: 2-flop synchronizer, debounce counter, rising-edge pulse
  // ---------------------------------------------------------------------------
  logic          sync1_q, sync2_q;
  logic          db_level_q, db_level_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          btn_pulse_q, btn_pulse_d;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    // The counter only runs while the synced input disagrees with the
    // debounced level; any agreement (a bounce back) restarts it from zero.
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
    // Press edges only; releases are ignored.
    btn_pulse_d = db_level_d & ~db_level_q;
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_level_q  <= 1'b0;
      db_cnt_q    <= '0;
      btn_pulse_q <= 1'b0;
    end else begin
      sync1_q     <= btnC;
      sync2_q     <= sync1_q;
      db_level_q  <= db_level_d;
      db_cnt_q    <= db_cnt_d;
      btn_pulse_q <= btn_pulse_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase timer FSM with one-second prescaler
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          trig_q, trig_d;
  logic [1:0]    phase_q, phase_d;
  logic [3:0]    secs_q, secs_d;

  logic          sec_tick;
  logic [3:0]    field_raw;
  logic [3:0]    field_secs;

  assign sec_tick = (state_q == ST_COUNT) && (presc_q == TICK_LAST);

  // Duration field for the phase about to be loaded; 0 means "use default".
  always_comb begin
    case (phase_q)
      2'd0:    field_raw = sw[3:0];
      2'd1:    field_raw = sw[7:4];
      2'd2:    field_raw = sw[11:8];
      default: field_raw = sw[15:12];
    endcase
    field_secs = (field_raw == 4'd0) ? DEFAULT_FIELD : field_raw;
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    trig_d  = 1'b0;
    phase_d = phase_q;
    secs_d  = secs_q;
    case (state_q)
      ST_LOAD: begin
        // sw is sampled only here, so mid-phase changes wait for the next entry.
        secs_d  = field_secs;
        presc_d = '0;
        state_d = ST_COUNT;
      end
      ST_COUNT: begin
        presc_d = sec_tick ? '0 : presc_q + PW'(1);
        // A button press and an expiry in the same cycle share one advance.
        if (btn_pulse_q || (sec_tick && secs_q == 4'd1)) begin
          state_d = ST_FIRE;
          trig_d  = 1'b1;
          phase_d = phase_q + 2'd1;
        end else if (sec_tick) begin
          secs_d = secs_q - 4'd1;
        end
      end
      ST_FIRE: begin
        // trig_d defaults low, ending the pulse after one cycle.
        state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // NOTE: the reset branch clears every flop, outputs included, so the
  // outputs drop to zero as soon as rst_n falls without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      presc_q <= '0;
      trig_q  <= 1'b0;
      phase_q <= 2'd0;
      secs_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      trig_q  <= trig_d;
      phase_q <= phase_d;
      secs_q  <= secs_d;
    end
  end

  assign trig      = trig_q;
  assign phase     = phase_q;
  assign secs_left = secs_q;

endmodule

// File: tb/tb_phase_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_phase_tick_gen
//
// Directed bench for phase_tick_gen with TICK_DIV=10 and DEBOUNCE_CYCLES=4.
// Outputs are sampled on the falling clock edge; inputs change there too.
// Cycle distances are counted in falling edges between observations. With
// these parameters a phase of N seconds spans N*10+2 cycles FIRE to FIRE.
// -----------------------------------------------------------------------------
module tb_phase_tick_gen;

  localparam int unsigned TICK_DIV        = 10;
  localparam int unsigned DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEFAULT_SECS    = 5;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        btnC  = 1'b0;
  logic [15:0] sw    = 16'h4321;
  logic        trig;
  logic [1:0]  phase;
  logic [3:0]  secs_left;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  phase_tick_gen #(
    .TICK_DIV        (TICK_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DEFAULT_SECS    (DEFAULT_SECS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btnC      (btnC),
    .sw        (sw),
    .trig      (trig),
    .phase     (phase),
    .secs_left (secs_left)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Falling edges until trig is seen high (at least one); bounded.
  task automatic next_trig(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (trig !== 1'b1 && n < 400);
  endtask

  initial begin
    int n;
    int ntr;
    int first_at;
    int sl16;

    // ---------------- reset with sw = 4321 ----------------
    repeat (3) @(negedge clk);
    check("reset_trig",  int'(trig),      0);
    check("reset_phase", int'(phase),     0);
    check("reset_secs",  int'(secs_left), 0);

    rst_n = 1'b1;
    @(negedge clk);
    // One LOAD edge has passed: phase 0 field is 1.
    check("first_load_secs",  int'(secs_left), 1);
    check("first_load_phase", int'(phase),     0);
    check("first_load_trig",  int'(trig),      0);

    next_trig(n);
    check("first_trig_delay", n, 10);          // 11th edge after release
    check("first_trig_phase", int'(phase), 1);
    @(negedge clk);
    check("trig_one_cycle", int'(trig), 0);
    @(negedge clk);
    check("phase1_load_secs", int'(secs_left), 2);
    next_trig(n);
    check("phase1_len", n, 20);                // 22 total minus the 2 above
    check("phase2_idx", int'(phase), 2);
    next_trig(n);
    check("phase2_len", n, 32);
    check("phase3_idx", int'(phase), 3);
    next_trig(n);
    check("phase3_len", n, 42);
    check("wrap_idx", int'(phase), 0);

    // ---------------- all-zero switches: default 5 s ----------------
    sw = 16'h0000;
    for (int p = 1; p <= 4; p++) begin
      next_trig(n);
      check("default_len", n, 52);
      check("default_idx", int'(phase), p % 4);
    end

    // ---------------- bouncy button in phase 0 ----------------
    sw = 16'h0070;                             // phase 0 -> 5 s, phase 1 -> 7 s
    repeat (3) @(negedge clk);
    ntr = 0; first_at = -1; sl16 = 0;
    for (int i = 0; i < 30; i++) begin
      btnC = (i < 10) ? ((i / 2) % 2 == 0) : 1'b1;   // final rise at step 8
      @(negedge clk);
      if (trig === 1'b1) begin
        ntr++;
        if (first_at < 0) first_at = i;
      end
      if (i == 16) sl16 = int'(secs_left);
    end
    check("bounce_trig_count", ntr, 1);
    // 2 sync + 4 debounce + 1 edge pulse after the rise at step 8
    check("bounce_trig_step", first_at, 14);
    check("bounce_reload_secs", sl16, 7);
    check("bounce_phase", int'(phase), 1);

    btnC = 1'b0;                               // release: must not advance
    ntr = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (trig === 1'b1) ntr++;
    end
    check("release_no_trig", ntr, 0);
    next_trig(n);
    check("phase1_after_btn_len", n, 47);      // 72 from the button trig
    check("phase1_after_btn_idx", int'(phase), 2);

    // ---------------- button coincident with last tick ----------------
    sw = 16'h1110;                             // phase 2 -> 1 s
    ntr = 0; first_at = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (trig === 1'b1) begin
        ntr++;
        if (first_at < 0) first_at = i;
      end
      if (i == 5)  btnC = 1'b1;                // pulse lands on the expiry cycle
      if (i == 12) sw = 16'h1113;              // phase 3 -> 1 s, phase 0 -> 3 s
      if (i == 14) btnC = 1'b0;
    end
    check("coincident_trig_count", ntr, 1);
    check("coincident_trig_step",  first_at, 12);
    check("coincident_phase",      int'(phase), 3);
    next_trig(n);
    check("phase3_short_len", n, 4);
    check("phase3_wrap_idx", int'(phase), 0);

    // ---------------- sw change mid-phase ----------------
    repeat (2) @(negedge clk);
    check("midphase_secs", int'(secs_left), 3);
    sw = 16'h1119;
    next_trig(n);
    check("midphase_len_kept", n, 30);         // still 3 s
    check("midphase_idx", int'(phase), 1);
    next_trig(n);
    check("p1_len", n, 12);
    next_trig(n);
    check("p2_len", n, 12);
    next_trig(n);
    check("p3_len", n, 12);
    check("p3_idx", int'(phase), 0);
    next_trig(n);
    check("new_field_len", n, 92);             // 9 s now applies
    check("new_field_idx", int'(phase), 1);

    // ---------------- reset mid-COUNT in phase 2 ----------------
    sw = 16'h0519;                             // phase 1 -> 1 s, phase 2 -> 5 s
    next_trig(n);
    check("pre_reset_len", n, 12);
    check("pre_reset_idx", int'(phase), 2);
    repeat (20) @(negedge clk);
    check("pre_reset_secs",  int'(secs_left), 4);
    check("pre_reset_phase", int'(phase),     2);
    #2 rst_n = 1'b0;
    #1;                                        // still before the next rising edge
    check("async_reset_trig",  int'(trig),      0);
    check("async_reset_phase", int'(phase),     0);
    check("async_reset_secs",  int'(secs_left), 0);
    ntr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (trig === 1'b1) ntr++;
    end
    check("reset_no_trig", ntr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_phase", int'(phase),     0);
    check("restart_secs",  int'(secs_left), 9);
    next_trig(n);
    check("restart_len", n, 90);
    check("restart_idx", int'(phase), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
